// File: rtl/button_conditioner_pkg.sv
// Shared watch constants: 50 MHz timing defaults, button indices and the
// per-channel conditioner state encoding.
package button_conditioner_pkg;

  localparam int unsigned DEB_CYC_50M  = 1_000_000;
  localparam int unsigned HOLD_CYC_50M = 25_000_000;
  localparam int unsigned RPT_CYC_50M  = 5_000_000;

  localparam int unsigned MODE   = 0;
  localparam int unsigned START  = 1;
  localparam int unsigned CHANGE = 2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;
  localparam logic [1:0] StLong   = 2'd3;

  // Counter width sized by the largest cycle parameter.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce, and the
// press / hold / auto-repeat / long-press state machine.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYC   = 4,
  parameter int unsigned HOLD_CYC  = 20,
  parameter int unsigned RPT_CYC   = 5,
  parameter bit          REPEAT_EN = 1'b0,
  parameter int unsigned CNT_W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pulse,
  output logic held,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             held_q, held_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             long_q, long_d;

  assign sync = sync_q[1];

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    held_d    = held_q;
    if (sync == held_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      held_d    = sync;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // A debounced release wins over everything and never strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (held_q) begin
          state_d = StHold;
          pulse_d = 1'b1;
        end
      end
      StHold: begin
        if (!held_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (REPEAT_EN) begin
            state_d = StRepeat;
            pulse_d = 1'b1;
          end else begin
            state_d = StLong;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRepeat: begin
        if (!held_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLong: begin
        if (!held_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    long_d = (state_d == StRepeat) || (state_d == StLong);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b00;
      deb_cnt_q <= '0;
      held_q    <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ~key_n};
      deb_cnt_q <= deb_cnt_d;
      held_q    <= held_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      long_q    <= long_d;
    end
  end

  assign pulse      = pulse_q;
  assign held       = held_q;
  assign long_press = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low pushbuttons into press strobes, debounced
// levels and long-press flags; one independent btn_channel per button.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned          N_BTN     = 3,
  parameter int unsigned          DEB_CYC   = DEB_CYC_50M,
  parameter int unsigned          HOLD_CYC  = HOLD_CYC_50M,
  parameter int unsigned          RPT_CYC   = RPT_CYC_50M,
  parameter logic [N_BTN-1:0]     REPEAT_EN = N_BTN'(3'b100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] key_n,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] long_press
);

  localparam int unsigned CNT_W = cnt_width(DEB_CYC, HOLD_CYC, RPT_CYC);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEB_CYC   (DEB_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .RPT_CYC   (RPT_CYC),
      .REPEAT_EN (REPEAT_EN[i]),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[i]),
      .pulse      (pulse[i]),
      .held       (held[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters.
// Outputs are sampled on the falling edge; "cycle k" is the value seen before rising edge k.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] key_n;
  logic [2:0] pulse;
  logic [2:0] held;
  logic [2:0] long_press;

  int n_chk;
  int n_err;
  int pcount;

  button_conditioner #(
    .N_BTN     (3),
    .DEB_CYC   (4),
    .HOLD_CYC  (20),
    .RPT_CYC   (5),
    .REPEAT_EN (3'b100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .pulse      (pulse),
    .held       (held),
    .long_press (long_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] inr(input int k, input int a, input int b,
                                     input logic [2:0] m);
    return (k >= a && k <= b) ? m : 3'b000;
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    key_n = 3'b111;

    // Reset held, then quiet after release
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("reset_outs", k, {23'd0, pulse, held, long_press}, 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_reset_outs", k, {23'd0, pulse, held, long_press}, 32'd0);
    end

    // Short press on mode
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      key_n = (k < 12) ? 3'b110 : 3'b111;
      chk("mode_pulse", k, {29'd0, pulse}, {29'd0, (k == 7) ? 3'b001 : 3'b000});
      chk("mode_held", k, {29'd0, held}, {29'd0, inr(k, 6, 17, 3'b001)});
      chk("mode_long", k, {29'd0, long_press}, 32'd0);
    end

    // Bouncy press and bouncy release on start
    pcount = 0;
    for (int k = 0; k < 61; k++) begin
      logic low;
      @(negedge clk);
      low = (k < 12 && (k % 4) < 2) || (k >= 12 && k < 42) || (k >= 44 && k < 46);
      key_n = low ? 3'b101 : 3'b111;
      if (pulse[1]) pcount++;
      chk("start_pulse", k, {29'd0, pulse}, {29'd0, (k == 19) ? 3'b010 : 3'b000});
      chk("start_held", k, {29'd0, held}, {29'd0, inr(k, 18, 51, 3'b010)});
      chk("start_long", k, {29'd0, long_press}, {29'd0, inr(k, 39, 52, 3'b010)});
    end
    chk("start_pulse_count", 61, pcount, 1);

    // Long hold on change: auto-repeat
    for (int k = 0; k < 61; k++) begin
      logic rp;
      @(negedge clk);
      key_n = (k < 45) ? 3'b011 : 3'b111;
      rp = (k == 7) || (k == 27) || (k == 32) || (k == 37) || (k == 42) || (k == 47);
      chk("chg_pulse", k, {29'd0, pulse}, {29'd0, rp ? 3'b100 : 3'b000});
      chk("chg_held", k, {29'd0, held}, {29'd0, inr(k, 6, 50, 3'b100)});
      chk("chg_long", k, {29'd0, long_press}, {29'd0, inr(k, 27, 51, 3'b100)});
    end

    // Long hold on mode: no repeat
    for (int k = 0; k < 61; k++) begin
      @(negedge clk);
      key_n = (k < 45) ? 3'b110 : 3'b111;
      chk("mlong_pulse", k, {29'd0, pulse}, {29'd0, (k == 7) ? 3'b001 : 3'b000});
      chk("mlong_held", k, {29'd0, held}, {29'd0, inr(k, 6, 50, 3'b001)});
      chk("mlong_long", k, {29'd0, long_press}, {29'd0, inr(k, 27, 51, 3'b001)});
    end

    // Simultaneous press on all channels
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      key_n = (k < 10) ? 3'b000 : 3'b111;
      chk("all_pulse", k, {29'd0, pulse}, {29'd0, (k == 7) ? 3'b111 : 3'b000});
      chk("all_held", k, {29'd0, held}, {29'd0, inr(k, 6, 15, 3'b111)});
      chk("all_long", k, {29'd0, long_press}, 32'd0);
    end

    // Reset mid-hold on change, key still pressed afterwards
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      key_n = 3'b011;
      chk("rh_pulse", k, {29'd0, pulse}, {29'd0, (k == 7 || k == 27) ? 3'b100 : 3'b000});
      chk("rh_held", k, {29'd0, held}, {29'd0, (k >= 6) ? 3'b100 : 3'b000});
      chk("rh_long", k, {29'd0, long_press}, {29'd0, (k >= 27) ? 3'b100 : 3'b000});
    end
    reset = 1'b0;
    #1;
    chk("async_reset_outs", 30, {23'd0, pulse, held, long_press}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("in_reset_outs", 30 + i, {23'd0, pulse, held, long_press}, 32'd0);
    end
    reset = 1'b1;
    for (int r = 1; r < 43; r++) begin
      logic rp;
      @(negedge clk);
      key_n = (r < 29) ? 3'b011 : 3'b111;
      rp = (r == 7) || (r == 27) || (r == 32);
      chk("ar_pulse", r, {29'd0, pulse}, {29'd0, rp ? 3'b100 : 3'b000});
      chk("ar_held", r, {29'd0, held}, {29'd0, inr(r, 6, 34, 3'b100)});
      chk("ar_long", r, {29'd0, long_press}, {29'd0, inr(r, 27, 35, 3'b100)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
